// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus bundle: EXU/LSU requests, register-file
// write port and decode scoreboard lookups.
interface rf_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  exu_valid;
  logic                  exu_ready;
  logic [ADDR_WIDTH-1:0] exu_waddr;
  logic [DATA_WIDTH-1:0] exu_wdata;

  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_waddr;
  logic [DATA_WIDTH-1:0] lsu_wdata;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic                  issue_ready;

  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic                  rs1_busy;
  logic                  rs2_busy;

  modport master (
    output exu_valid, exu_waddr, exu_wdata,
    output lsu_valid, lsu_waddr, lsu_wdata,
    output issue_valid, issue_rd,
    output rs1_addr, rs2_addr,
    input  exu_ready, lsu_ready,
    input  rf_wen, rf_waddr, rf_wdata,
    input  issue_ready, rs1_busy, rs2_busy
  );

  modport slave (
    input  exu_valid, exu_waddr, exu_wdata,
    input  lsu_valid, lsu_waddr, lsu_wdata,
    input  issue_valid, issue_rd,
    input  rs1_addr, rs2_addr,
    output exu_ready, lsu_ready,
    output rf_wen, rf_waddr, rf_wdata,
    output issue_ready, rs1_busy, rs2_busy
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: round-robin EXU/LSU
// sharing of the write port plus a pending-write scoreboard.
module rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int NREG = 2 ** ADDR_WIDTH;

  typedef enum logic {
    GNT_EXU = 1'b0,
    GNT_LSU = 1'b1
  } gnt_e;

  gnt_e                  last_grant_q;
  gnt_e                  last_grant_d;
  logic                  exu_gnt;
  logic                  lsu_gnt;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_waddr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  rf_wen_q;
  logic                  rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic [DATA_WIDTH-1:0] rf_wdata_d;

  logic [NREG-1:0]       busy_q;
  logic [NREG-1:0]       busy_d;
  logic                  issue_ok;
  logic                  issue_set;

  // Round-robin grant: on a tie the requester not granted last wins.
  always_comb begin
    exu_gnt = bus.exu_valid &&
              (!bus.lsu_valid || last_grant_q == GNT_LSU);
    lsu_gnt = bus.lsu_valid &&
              (!bus.exu_valid || last_grant_q == GNT_EXU);
    accept  = exu_gnt || lsu_gnt;
    sel_waddr    = '0;
    sel_wdata    = '0;
    last_grant_d = last_grant_q;
    unique case (1'b1)
      exu_gnt: begin
        sel_waddr    = bus.exu_waddr;
        sel_wdata    = bus.exu_wdata;
        last_grant_d = GNT_EXU;
      end
      lsu_gnt: begin
        sel_waddr    = bus.lsu_waddr;
        sel_wdata    = bus.lsu_wdata;
        last_grant_d = GNT_LSU;
      end
      default: begin
        sel_waddr    = '0;
        sel_wdata    = '0;
        last_grant_d = last_grant_q;
      end
    endcase
  end

  // Output stage: load on accept, pulse wen one cycle, x0 never written.
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (accept) begin
      rf_wen_d   = (sel_waddr != '0);
      rf_waddr_d = sel_waddr;
      rf_wdata_d = sel_wdata;
    end
  end

  // Scoreboard: clear on the completing write, set on issue.
  always_comb begin
    issue_ok  = !busy_q[bus.issue_rd];
    issue_set = bus.issue_valid && issue_ok &&
                (bus.issue_rd != '0);
    busy_d = busy_q;
    if (rf_wen_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (issue_set) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GNT_LSU;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.exu_ready   = exu_gnt;
  assign bus.lsu_ready   = lsu_gnt;
  assign bus.rf_wen      = rf_wen_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.issue_ready = issue_ok;
  assign bus.rs1_busy    = busy_q[bus.rs1_addr];
  assign bus.rs2_busy    = busy_q[bus.rs2_addr];
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: handshake, round-robin,
// scoreboard, x0 and mid-flight reset behaviour.
module tb_rf_wb_arbiter;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  rf_wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.exu_valid   = 1'b0;
    bus.lsu_valid   = 1'b0;
    bus.issue_valid = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.exu_valid   = 1'b0;
    bus.exu_waddr   = '0;
    bus.exu_wdata   = '0;
    bus.lsu_valid   = 1'b0;
    bus.lsu_waddr   = '0;
    bus.lsu_wdata   = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.rs1_addr    = '0;
    bus.rs2_addr    = '0;

    // reset state
    step();
    step();
    rst = 1'b0;
    bus.issue_rd = 5'd5;
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd9;
    settle();
    chk("rst_wen", bus.rf_wen, 0);
    chk("rst_waddr", bus.rf_waddr, 0);
    chk("rst_wdata", bus.rf_wdata, 0);
    chk("rst_issue_ready", bus.issue_ready, 1);
    chk("rst_rs1_busy", bus.rs1_busy, 0);
    chk("rst_rs2_busy", bus.rs2_busy, 0);
    chk("rst_exu_ready_idle", bus.exu_ready, 0);

    // single EXU write
    bus.exu_valid = 1'b1;
    bus.exu_waddr = 5'd5;
    bus.exu_wdata = 32'hDEADBEEF;
    settle();
    chk("exu1_ready", bus.exu_ready, 1);
    chk("exu1_lsu_ready", bus.lsu_ready, 0);
    step();
    idle();
    settle();
    chk("exu1_wen", bus.rf_wen, 1);
    chk("exu1_waddr", bus.rf_waddr, 5);
    chk("exu1_wdata", bus.rf_wdata, 32'hDEADBEEF);
    step();
    chk("exu1_wen_drop", bus.rf_wen, 0);
    chk("exu1_addr_hold", bus.rf_waddr, 5);

    // single LSU write (also leaves last_grant = LSU)
    bus.lsu_valid = 1'b1;
    bus.lsu_waddr = 5'd6;
    bus.lsu_wdata = 32'h6666_0006;
    settle();
    chk("lsu1_ready", bus.lsu_ready, 1);
    chk("lsu1_exu_ready", bus.exu_ready, 0);
    step();
    idle();
    settle();
    chk("lsu1_wen", bus.rf_wen, 1);
    chk("lsu1_wdata", bus.rf_wdata, 32'h6666_0006);

    // contention with backpressure hold
    bus.exu_valid = 1'b1;
    bus.exu_waddr = 5'd1;
    bus.exu_wdata = 32'h1111_0001;
    bus.lsu_valid = 1'b1;
    bus.lsu_waddr = 5'd2;
    bus.lsu_wdata = 32'h2222_0002;
    settle();
    chk("c0_exu_ready", bus.exu_ready, 1);
    chk("c0_lsu_ready", bus.lsu_ready, 0);
    step();
    bus.exu_waddr = 5'd3;
    bus.exu_wdata = 32'h3333_0003;
    settle();
    chk("c1_lsu_ready", bus.lsu_ready, 1);
    chk("c1_exu_ready", bus.exu_ready, 0);
    chk("c1_wen", bus.rf_wen, 1);
    chk("c1_waddr", bus.rf_waddr, 1);
    chk("c1_wdata", bus.rf_wdata, 32'h1111_0001);
    step();
    bus.lsu_waddr = 5'd4;
    bus.lsu_wdata = 32'h4444_0004;
    settle();
    chk("c2_exu_ready", bus.exu_ready, 1);
    chk("c2_lsu_ready", bus.lsu_ready, 0);
    chk("c2_wen", bus.rf_wen, 1);
    chk("c2_waddr", bus.rf_waddr, 2);
    chk("c2_wdata", bus.rf_wdata, 32'h2222_0002);
    step();
    bus.exu_waddr = 5'd10;
    bus.exu_wdata = 32'hAAAA_000A;
    settle();
    chk("c3_lsu_ready", bus.lsu_ready, 1);
    chk("c3_exu_ready", bus.exu_ready, 0);
    chk("c3_wen", bus.rf_wen, 1);
    chk("c3_wdata", bus.rf_wdata, 32'h3333_0003);
    step();
    bus.lsu_valid = 1'b0;
    settle();
    chk("c4_exu_ready", bus.exu_ready, 1);
    chk("c4_wen", bus.rf_wen, 1);
    chk("c4_waddr", bus.rf_waddr, 4);
    chk("c4_wdata", bus.rf_wdata, 32'h4444_0004);
    step();
    idle();
    settle();
    chk("c5_wen", bus.rf_wen, 1);
    chk("c5_waddr", bus.rf_waddr, 10);
    chk("c5_wdata", bus.rf_wdata, 32'hAAAA_000A);
    step();
    chk("c6_wen", bus.rf_wen, 0);

    // scoreboard on x7
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    bus.rs1_addr    = 5'd7;
    bus.rs2_addr    = 5'd7;
    settle();
    chk("sb_issue_ready_pre", bus.issue_ready, 1);
    chk("sb_rs1_busy_pre", bus.rs1_busy, 0);
    step();
    idle();
    settle();
    chk("sb_rs1_busy", bus.rs1_busy, 1);
    chk("sb_rs2_busy", bus.rs2_busy, 1);
    chk("sb_issue_ready_waw", bus.issue_ready, 0);
    bus.rs2_addr = 5'd8;
    settle();
    chk("sb_rs2_other", bus.rs2_busy, 0);
    bus.lsu_valid = 1'b1;
    bus.lsu_waddr = 5'd7;
    bus.lsu_wdata = 32'h7777_0007;
    settle();
    chk("sb_lsu_ready", bus.lsu_ready, 1);
    step();
    idle();
    settle();
    chk("sb_wen", bus.rf_wen, 1);
    chk("sb_waddr", bus.rf_waddr, 7);
    chk("sb_busy_in_wen", bus.rs1_busy, 1);
    chk("sb_issue_in_wen", bus.issue_ready, 0);
    step();
    chk("sb_busy_cleared", bus.rs1_busy, 0);
    chk("sb_issue_after", bus.issue_ready, 1);
    chk("sb_wen_drop", bus.rf_wen, 0);

    // x0 handling
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd0;
    bus.rs1_addr    = 5'd0;
    bus.exu_valid   = 1'b1;
    bus.exu_waddr   = 5'd0;
    bus.exu_wdata   = 32'h0000_1234;
    settle();
    chk("x0_issue_ready", bus.issue_ready, 1);
    chk("x0_exu_ready", bus.exu_ready, 1);
    step();
    idle();
    settle();
    chk("x0_busy", bus.rs1_busy, 0);
    chk("x0_wen", bus.rf_wen, 0);
    step();
    chk("x0_wen_after", bus.rf_wen, 0);

    // reset mid-flight
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd3;
    bus.rs1_addr    = 5'd3;
    bus.lsu_valid   = 1'b1;
    bus.lsu_waddr   = 5'd9;
    bus.lsu_wdata   = 32'h9999_0009;
    settle();
    chk("mr_lsu_ready", bus.lsu_ready, 1);
    step();
    idle();
    settle();
    chk("mr_wen", bus.rf_wen, 1);
    chk("mr_busy3", bus.rs1_busy, 1);
    rst = 1'b1;
    bus.exu_valid = 1'b1;
    bus.exu_waddr = 5'd11;
    bus.exu_wdata = 32'hBBBB_000B;
    step();
    rst = 1'b0;
    idle();
    settle();
    chk("mr_wen_after", bus.rf_wen, 0);
    chk("mr_waddr_after", bus.rf_waddr, 0);
    chk("mr_busy3_after", bus.rs1_busy, 0);
    bus.exu_valid = 1'b1;
    bus.exu_waddr = 5'd12;
    bus.exu_wdata = 32'hCCCC_000C;
    bus.lsu_valid = 1'b1;
    bus.lsu_waddr = 5'd13;
    bus.lsu_wdata = 32'hDDDD_000D;
    settle();
    chk("mr_tie_exu", bus.exu_ready, 1);
    chk("mr_tie_lsu", bus.lsu_ready, 0);
    step();
    bus.exu_valid = 1'b0;
    settle();
    chk("mr_lsu_next", bus.lsu_ready, 1);
    chk("mr_wdata12", bus.rf_wdata, 32'hCCCC_000C);
    step();
    idle();
    settle();
    chk("mr_wdata13", bus.rf_wdata, 32'hDDDD_000D);
    chk("mr_waddr13", bus.rf_waddr, 13);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
